// File: rtl/mvm_pkg.sv
// Shared sequencer state encoding and {tlast, tuser, tdata} beat field offsets.
package mvm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    localparam int TDATA_LSB = 0;

    function automatic int tuser_lsb(input int dataw);
        return dataw;
    endfunction

    function automatic int tlast_bit(input int dataw, input int userw);
        return dataw + userw;
    endfunction

endpackage

// File: rtl/axis_resp_fifo.sv
// First-word fall-through response FIFO; data is visible the cycle after its push.
// A push is refused while full, even when a pop happens in the same cycle.
module axis_resp_fifo #(
    parameter int W     = 512,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld_i,
    input  logic [W-1:0] push_dat_i,
    output logic         full_o,
    output logic         pop_vld_o,
    output logic [W-1:0] pop_dat_o,
    input  logic         pop_rdy_i
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          push, pop;

    assign full_o    = (cnt_q == CW'(DEPTH));
    assign pop_vld_o = (cnt_q != '0);
    assign pop_dat_o = mem_q[rd_q];
    assign push      = push_vld_i && !full_o;
    assign pop       = pop_vld_o && pop_rdy_i;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= push_dat_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= (wr_q == LAST) ? '0 : wr_q + AW'(1);
            if (pop)  rd_q <= (rd_q == LAST) ? '0 : rd_q + AW'(1);
            if (push && !pop)      cnt_q <= cnt_q + CW'(1);
            else if (pop && !push) cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/mvm_axis_sequencer.sv
// Replays a stored AXIS program (num_beats x loops) toward the MVM and collects its responses.
// First beat is valid the cycle after start; payload holds under m_tready stalls; s_tready = !resp FIFO full.
module mvm_axis_sequencer
    import mvm_pkg::*;
#(
    parameter int DATAW   = 512,
    parameter int USERW   = 75,
    parameter int DEPTH   = 128,
    parameter int RESPD   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       prog_we,
    input  logic [$clog2(DEPTH)-1:0]   prog_addr,
    input  logic [DATAW+USERW:0]       prog_wdata,
    input  logic                       start,
    input  logic                       stop,
    input  logic [$clog2(DEPTH):0]     num_beats,
    input  logic [7:0]                 loops,
    input  logic [15:0]                exp_resp,
    output logic                       m_tvalid,
    output logic [DATAW-1:0]           m_tdata,
    output logic [USERW-1:0]           m_tuser,
    output logic                       m_tlast,
    input  logic                       m_tready,
    input  logic                       s_tvalid,
    input  logic [DATAW-1:0]           s_tdata,
    output logic                       s_tready,
    output logic                       resp_valid,
    output logic [DATAW-1:0]           resp_data,
    input  logic                       resp_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       err_timeout
);
    localparam int PADDRW    = $clog2(DEPTH);
    localparam int BEATW     = DATAW + USERW + 1;
    localparam int TUSER_LSB = tuser_lsb(DATAW);
    localparam int TLAST_BIT = tlast_bit(DATAW, USERW);
    localparam int IDLEW     = $clog2(TIMEOUT + 1);
    localparam logic [IDLEW-1:0]  IDLE_LAST = IDLEW'(TIMEOUT - 1);
    localparam logic [PADDRW-1:0] BEAT0     = '0;

    logic [BEATW-1:0]  prog_mem [DEPTH];
    seq_state_t        state_q;
    logic [PADDRW-1:0] beat_q, next_beat_d;
    logic [7:0]        loop_q, loops_q;
    logic [PADDRW:0]   nb_q;
    logic [15:0]       exp_q, resp_cnt_q, resp_cnt_d;
    logic [IDLEW-1:0]  idle_q;
    logic [BEATW-1:0]  m_beat_q;
    logic              m_tvalid_q, busy_q, done_q, err_q, stop_q;
    logic              fifo_full, resp_push, m_hs, last_beat, last_pass;

    assign resp_push   = s_tvalid && !fifo_full;
    assign resp_cnt_d  = (resp_push && resp_cnt_q != 16'hFFFF) ? resp_cnt_q + 16'd1 : resp_cnt_q;
    assign m_hs        = m_tvalid_q && m_tready;
    assign last_beat   = ({1'b0, beat_q} == nb_q - (PADDRW+1)'(1));
    assign last_pass   = (loop_q == loops_q - 8'd1);
    assign next_beat_d = last_beat ? '0 : beat_q + PADDRW'(1);

    // Program memory has no reset so a rerun after rst replays the same program.
    always_ff @(posedge clk) begin
        if (prog_we && !busy_q) prog_mem[prog_addr] <= prog_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            beat_q     <= '0;
            loop_q     <= '0;
            nb_q       <= '0;
            loops_q    <= '0;
            exp_q      <= '0;
            resp_cnt_q <= '0;
            idle_q     <= '0;
            m_beat_q   <= '0;
            m_tvalid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            resp_cnt_q <= resp_cnt_d;
            done_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        nb_q       <= num_beats;
                        loops_q    <= loops;
                        exp_q      <= exp_resp;
                        beat_q     <= '0;
                        loop_q     <= '0;
                        resp_cnt_q <= '0;
                        idle_q     <= '0;
                        err_q      <= 1'b0;
                        stop_q     <= 1'b0;
                        if (num_beats == '0 || loops == 8'd0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= ST_RUN;
                            busy_q     <= 1'b1;
                            m_tvalid_q <= 1'b1;
                            m_beat_q   <= prog_mem[BEAT0];
                        end
                    end
                end
                ST_RUN: begin
                    if (stop) stop_q <= 1'b1;
                    if (m_hs) begin
                        if (stop || stop_q || (last_beat && last_pass)) begin
                            m_tvalid_q <= 1'b0;
                            if (!(stop || stop_q) && resp_cnt_d < exp_q) begin
                                state_q <= ST_DRAIN;
                                idle_q  <= '0;
                            end else begin
                                state_q <= ST_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            beat_q   <= next_beat_d;
                            m_beat_q <= prog_mem[next_beat_d];
                            if (last_beat) loop_q <= loop_q + 8'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (stop || resp_cnt_d >= exp_q || (!resp_push && idle_q == IDLE_LAST)) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= !stop && resp_cnt_d < exp_q;
                    end else if (resp_push) begin
                        idle_q <= '0;
                    end else begin
                        idle_q <= idle_q + IDLEW'(1);
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_tvalid    = m_tvalid_q;
    assign m_tdata     = m_beat_q[TDATA_LSB +: DATAW];
    assign m_tuser     = m_beat_q[TUSER_LSB +: USERW];
    assign m_tlast     = m_beat_q[TLAST_BIT];
    assign s_tready    = !fifo_full;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_timeout = err_q;

    axis_resp_fifo #(
        .W     (DATAW),
        .DEPTH (RESPD)
    ) u_resp_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_vld_i (s_tvalid),
        .push_dat_i (s_tdata),
        .full_o     (fifo_full),
        .pop_vld_o  (resp_valid),
        .pop_dat_o  (resp_data),
        .pop_rdy_i  (resp_ready)
    );

endmodule

// File: tb/tb_mvm_axis_sequencer.sv
// Randomized bench for mvm_axis_sequencer against a queue-based model of the beat stream and response FIFO.
module tb_mvm_axis_sequencer;
    localparam int DATAW   = 32;
    localparam int USERW   = 8;
    localparam int DEPTH   = 16;
    localparam int RESPD   = 16;
    localparam int TIMEOUT = 16;
    localparam int PADDRW  = $clog2(DEPTH);
    localparam int BEATW   = DATAW + USERW + 1;

    logic              clk = 1'b0;
    logic              rst, prog_we, start, stop;
    logic [PADDRW-1:0] prog_addr;
    logic [BEATW-1:0]  prog_wdata;
    logic [PADDRW:0]   num_beats;
    logic [7:0]        loops;
    logic [15:0]       exp_resp;
    logic              m_tvalid, m_tlast, m_tready;
    logic [DATAW-1:0]  m_tdata;
    logic [USERW-1:0]  m_tuser;
    logic              s_tvalid, s_tready;
    logic [DATAW-1:0]  s_tdata;
    logic              resp_valid, resp_ready;
    logic [DATAW-1:0]  resp_data;
    logic              busy, done, err_timeout;

    always #5 clk = ~clk;

    mvm_axis_sequencer #(
        .DATAW(DATAW), .USERW(USERW), .DEPTH(DEPTH), .RESPD(RESPD), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .start(start), .stop(stop), .num_beats(num_beats), .loops(loops), .exp_resp(exp_resp),
        .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tlast(m_tlast), .m_tready(m_tready),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tready(s_tready),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
        .busy(busy), .done(done), .err_timeout(err_timeout)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference state: programmed beats, observed beat stream, expected FIFO contents.
    logic [BEATW-1:0] prog [DEPTH];
    logic [BEATW-1:0] got_q [$];
    int               hs_edge_q [$];
    logic [DATAW-1:0] resp_model_q [$];
    logic [DATAW-1:0] send_q [$];
    int cyc = 0, send_after = 0, gap_n = 0, start_edge = 0;
    int tready_mode = 0, pop_mode = 0, send_rand = 0;
    int last_push_edge = -1, done_edge = -1, done_cnt = 0;

    task automatic drive_inputs();
        case (tready_mode)
            0: m_tready = 1'b1;
            1: m_tready = cyc[0];
            2: m_tready = ($urandom_range(0, 3) != 0);
            default: ;
        endcase
        resp_ready = (pop_mode == 1) || (pop_mode == 2 && $urandom_range(0, 1) == 1);
        if (s_tvalid && !s_tready) begin
            // hold a refused beat
        end else if (send_q.size() > 0 && cyc >= send_after &&
                     (send_rand == 0 || gap_n >= 2 || $urandom_range(0, 1) == 1)) begin
            s_tvalid = 1'b1;
            s_tdata  = send_q[0];
            gap_n    = 0;
        end else begin
            s_tvalid = 1'b0;
            gap_n++;
        end
    endtask

    task automatic tick();
        logic             stall;
        logic [BEATW-1:0] held;
        stall = m_tvalid && !m_tready && !rst;
        held  = {m_tlast, m_tuser, m_tdata};
        if (m_tvalid && m_tready) begin
            got_q.push_back(held);
            hs_edge_q.push_back(cyc + 1);
        end
        if (s_tvalid && s_tready) begin
            resp_model_q.push_back(s_tdata);
            last_push_edge = cyc + 1;
            if (send_q.size() > 0) send_q.delete(0);
        end
        if (resp_valid && resp_ready) begin
            check_eq("resp_avail", resp_model_q.size() > 0, 1);
            if (resp_model_q.size() > 0) begin
                check_eq("resp_dat", resp_data, resp_model_q[0]);
                resp_model_q.delete(0);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (stall && !rst) begin
            check_eq("stall_vld", m_tvalid, 1);
            check_eq("stall_dat", {m_tlast, m_tuser, m_tdata}, held);
        end
        if (done) begin
            done_cnt++;
            done_edge = cyc;
        end
    endtask

    task automatic step();
        drive_inputs();
        tick();
    endtask

    task automatic start_run(input int nb, input int lp, input int ex, input int delay);
        got_q.delete();
        hs_edge_q.delete();
        done_cnt   = 0;
        done_edge  = -1;
        send_after = cyc + 1 + delay;
        num_beats  = (PADDRW+1)'(nb);
        loops      = 8'(lp);
        exp_resp   = 16'(ex);
        start      = 1'b1;
        step();
        start      = 1'b0;
        start_edge = cyc;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            step();
            n++;
        end
        check_eq("done_seen", done, 1);
        check_eq("done_busy", busy, 0);
        step();
        check_eq("done_width", done, 0);
        check_eq("done_count", done_cnt, 1);
    endtask

    task automatic check_beats(input int nb, input int lp);
        check_eq("beat_count", got_q.size(), nb * lp);
        for (int i = 0; i < nb * lp && i < got_q.size(); i++)
            check_eq("beat", got_q[i], prog[i % nb]);
    endtask

    task automatic drain_fifo();
        pop_mode = 1;
        repeat (RESPD + 2) step();
        pop_mode = 0;
        check_eq("fifo_empty", resp_model_q.size(), 0);
        check_eq("fifo_vld0", resp_valid, 0);
    endtask

    initial begin
        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0; start = 1'b0; stop = 1'b0;
        num_beats = '0; loops = '0; exp_resp = '0; m_tready = 1'b0; s_tvalid = 1'b0; s_tdata = '0;
        resp_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        check_eq("rst_tvalid", m_tvalid, 0);
        check_eq("rst_resp_vld", resp_valid, 0);
        check_eq("rst_s_tready", s_tready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err_timeout, 0);

        for (int a = 0; a < DEPTH; a++) begin
            prog[a]    = {1'(a % 4 == 3), 8'($urandom), 32'($urandom)};
            prog_we    = 1'b1;
            prog_addr  = PADDRW'(a);
            prog_wdata = prog[a];
            step();
        end
        prog_we = 1'b0;

        // Back-to-back replay, two passes of four beats.
        tready_mode = 0;
        start_run(4, 2, 0, 0);
        check_eq("first_vld", m_tvalid, 1);
        check_eq("first_beat", {m_tlast, m_tuser, m_tdata}, prog[0]);
        check_eq("busy_run", busy, 1);
        wait_done(100);
        check_beats(4, 2);
        for (int i = 0; i < hs_edge_q.size(); i++)
            check_eq("b2b_edge", hs_edge_q[i], start_edge + 1 + i);

        // Toggling m_tready.
        tready_mode = 1;
        start_run(4, 2, 0, 0);
        wait_done(200);
        check_beats(4, 2);

        // Degenerate starts emit nothing and pulse done right away.
        tready_mode = 0;
        start_run(0, 2, 0, 0);
        check_eq("nb0_done", done, 1);
        check_eq("nb0_vld", m_tvalid, 0);
        wait_done(4);
        check_eq("nb0_beats", got_q.size(), 0);
        start_run(3, 0, 0, 0);
        check_eq("lp0_done", done, 1);
        wait_done(4);
        check_eq("lp0_beats", got_q.size(), 0);

        // Three expected responses, all delivered.
        send_rand = 1;
        for (int i = 0; i < 3; i++) send_q.push_back(32'($urandom));
        start_run(2, 1, 3, 0);
        wait_done(200);
        check_eq("drain_err", err_timeout, 0);
        check_eq("drain_fifo_n", resp_model_q.size(), 3);
        drain_fifo();

        // Two expected, one delivered during DRAIN: timeout.
        send_rand = 0;
        send_q.push_back(32'($urandom));
        start_run(1, 1, 2, 2);
        wait_done(100);
        check_eq("to_latency", done_edge - last_push_edge, TIMEOUT);
        check_eq("to_err", err_timeout, 1);
        repeat (3) step();
        check_eq("to_err_sticky", err_timeout, 1);
        drain_fifo();

        // Fill the response FIFO, then free one slot.
        for (int i = 0; i < RESPD + 1; i++) send_q.push_back(32'($urandom));
        send_after = 0;
        repeat (RESPD) step();
        check_eq("fill_n", resp_model_q.size(), RESPD);
        check_eq("fill_rdy", s_tready, 0);
        check_eq("fill_vld", s_tvalid, 1);
        pop_mode = 1;
        step();
        pop_mode = 0;
        check_eq("pop_rdy", s_tready, 1);
        check_eq("pop_n", resp_model_q.size(), RESPD - 1);
        drain_fifo();
        check_eq("send_left", send_q.size(), 0);

        // Stop while the first beat is stalled.
        check_eq("err_hold", err_timeout, 1);
        tready_mode = 3;
        m_tready = 1'b0;
        start_run(4, 3, 0, 0);
        check_eq("err_clear", err_timeout, 0);
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        repeat (2) step();
        check_eq("stop_busy", busy, 1);
        m_tready = 1'b1;
        wait_done(5);
        check_eq("stop_beats", got_q.size(), 1);
        check_eq("stop_beat0", got_q.size() > 0 ? got_q[0] : '0, prog[0]);
        check_eq("stop_vld", m_tvalid, 0);

        // Reset mid-run, then replay.
        tready_mode = 0;
        start_run(4, 3, 0, 0);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("mrst_vld", m_tvalid, 0);
        check_eq("mrst_busy", busy, 0);
        check_eq("mrst_done", done, 0);
        check_eq("mrst_rvld", resp_valid, 0);
        check_eq("mrst_srdy", s_tready, 1);
        step();
        check_eq("mrst_idle", m_tvalid, 0);
        tready_mode = 2;
        start_run(4, 1, 0, 0);
        wait_done(100);
        check_beats(4, 1);

        // Random programs, stalls, response timing and pops.
        for (int it = 0; it < 6; it++) begin
            int nb, lp, ex;
            nb = $urandom_range(1, DEPTH);
            lp = $urandom_range(1, 3);
            ex = $urandom_range(0, 4);
            send_rand = 1;
            for (int i = 0; i < ex; i++) send_q.push_back(32'($urandom));
            tready_mode = 2;
            pop_mode = 2;
            start_run(nb, lp, ex, $urandom_range(0, 3));
            wait_done(nb * lp * 8 + 200);
            check_beats(nb, lp);
            check_eq("rnd_err", err_timeout, 0);
            drain_fifo();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
